// File: rtl/counter_sequencer.sv
// Sequencer that runs an external up/down counter for a commanded number of enabled cycles.
// Optional Abort input is compiled in when COUNTER_SEQUENCER_ABORT_EN is defined.
module counter_sequencer #(
    parameter int N = 17,
    parameter int L = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    // Command handshake: a command transfers on a rising edge where Cmd_valid && Cmd_ready.
    // Cmd_ready is high only in IDLE; the source must hold its command until it transfers.
    input  logic         Cmd_valid,
    output logic         Cmd_ready,
    input  logic         Cmd_dir,
    input  logic [L-1:0] Cmd_steps,
    input  logic         Cmd_stop_on_wrap,
    output logic         Count_en,
    output logic         Up_Down_Ctrl,
    input  logic         Overflow_intr,
    input  logic         Underflow_intr,
`ifdef COUNTER_SEQUENCER_ABORT_EN
    input  logic         Abort,
`endif
    output logic         Busy,
    output logic         Done_pulse,
    output logic         Wrap_flag,
    output logic [L-1:0] Steps_done,
    output logic [1:0]   Dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [L-1:0] ONE = {{(L-1){1'b0}}, 1'b1};

    // N only describes the counter being driven; reject nonsensical widths at elaboration.
    if (N < 1 || L < 1) begin : g_bad_params
        $error("counter_sequencer: N and L must be at least 1");
    end

    state_e       state_q, state_d;
    logic         dir_q, dir_d;
    logic         stop_q, stop_d;
    logic         wrap_q, wrap_d;
    logic [L-1:0] remaining_q, remaining_d;
    logic [L-1:0] steps_done_q, steps_done_d;

    logic wrap_hit;
    logic last_step;
    logic abort_hit;

`ifdef COUNTER_SEQUENCER_ABORT_EN
    assign abort_hit = Abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Only the interrupt matching the latched direction counts as a wrap.
    assign wrap_hit  = dir_q ? Underflow_intr : Overflow_intr;
    assign last_step = (remaining_q == ONE);

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        stop_d       = stop_q;
        wrap_d       = wrap_q;
        remaining_d  = remaining_q;
        steps_done_d = steps_done_q;

        case (state_q)
            ST_IDLE: begin
                if (Cmd_valid) begin
                    dir_d        = Cmd_dir;
                    stop_d       = Cmd_stop_on_wrap;
                    remaining_d  = Cmd_steps;
                    wrap_d       = 1'b0;
                    steps_done_d = '0;
                    state_d      = (Cmd_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                steps_done_d = steps_done_q + ONE;
                remaining_d  = remaining_q - ONE;
                if (wrap_hit) begin
                    wrap_d = 1'b1;
                end
                // Exhaustion, wrap-stop and abort all collapse into one DONE.
                if (last_step || (stop_q && wrap_hit) || abort_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            stop_q       <= 1'b0;
            wrap_q       <= 1'b0;
            remaining_q  <= '0;
            steps_done_q <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            stop_q       <= stop_d;
            wrap_q       <= wrap_d;
            remaining_q  <= remaining_d;
            steps_done_q <= steps_done_d;
        end
    end

    assign Cmd_ready    = (state_q == ST_IDLE);
    assign Busy         = (state_q != ST_IDLE);
    assign Count_en     = (state_q == ST_RUN);
    assign Done_pulse   = (state_q == ST_DONE);
    assign Up_Down_Ctrl = dir_q;
    assign Wrap_flag    = wrap_q;
    assign Steps_done   = steps_done_q;
    assign Dbg_state    = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed plus randomized bench for counter_sequencer; expected run lengths come from a step-list model.
`timescale 1ns/1ps
module tb_counter_sequencer;

    localparam int L = 16;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Cmd_valid;
    logic         Cmd_ready;
    logic         Cmd_dir;
    logic [L-1:0] Cmd_steps;
    logic         Cmd_stop_on_wrap;
    logic         Count_en;
    logic         Up_Down_Ctrl;
    logic         Overflow_intr;
    logic         Underflow_intr;
`ifdef COUNTER_SEQUENCER_ABORT_EN
    logic         Abort;
`endif
    logic         Busy;
    logic         Done_pulse;
    logic         Wrap_flag;
    logic [L-1:0] Steps_done;
    logic [1:0]   Dbg_state;

    int checks = 0;
    int errors = 0;

    // Interrupt value presented during the k-th enabled cycle of a run.
    logic ovf_s[64];
    logic unf_s[64];
    int   abort_at_g = 0;
    logic [L-1:0] exp_q[$];

    counter_sequencer #(.N(4), .L(L)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Cmd_valid        (Cmd_valid),
        .Cmd_ready        (Cmd_ready),
        .Cmd_dir          (Cmd_dir),
        .Cmd_steps        (Cmd_steps),
        .Cmd_stop_on_wrap (Cmd_stop_on_wrap),
        .Count_en         (Count_en),
        .Up_Down_Ctrl     (Up_Down_Ctrl),
        .Overflow_intr    (Overflow_intr),
        .Underflow_intr   (Underflow_intr),
`ifdef COUNTER_SEQUENCER_ABORT_EN
        .Abort            (Abort),
`endif
        .Busy             (Busy),
        .Done_pulse       (Done_pulse),
        .Wrap_flag        (Wrap_flag),
        .Steps_done       (Steps_done),
        .Dbg_state        (Dbg_state)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sched;
        for (int i = 0; i < 64; i++) begin
            ovf_s[i] = 1'b0;
            unf_s[i] = 1'b0;
        end
    endtask

    // A run is a list of enabled cycles; it ends after the last one, or early on a
    // qualifying wrap with stop set, or on the abort cycle.
    task automatic ref_run(input logic dir, input int steps, input logic stop,
                           output int n, output logic wrap);
        n = 0;
        wrap = 1'b0;
        for (int i = 0; i < steps; i++) begin
            logic hit;
            hit = dir ? unf_s[i] : ovf_s[i];
            n = i + 1;
            if (hit) wrap = 1'b1;
            if ((stop && hit) || (abort_at_g == i + 1)) break;
        end
    endtask

    task automatic wait_done(input logic dir, input int budget,
                             output int n_en, output int cyc, output bit seen, output bit bad);
        seen = 1'b0;
        bad  = 1'b0;
        n_en = 0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            if (Done_pulse === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (Count_en === 1'b1) begin
                    Overflow_intr  = ovf_s[n_en % 64];
                    Underflow_intr = unf_s[n_en % 64];
`ifdef COUNTER_SEQUENCER_ABORT_EN
                    Abort = (abort_at_g != 0) && (n_en + 1 == abort_at_g);
`endif
                    n_en++;
                end
                if (Busy !== 1'b1 || Cmd_ready !== 1'b0 || Up_Down_Ctrl !== dir) bad = 1'b1;
                tick;
                cyc++;
            end
        end
        Overflow_intr  = 1'b0;
        Underflow_intr = 1'b0;
`ifdef COUNTER_SEQUENCER_ABORT_EN
        Abort = 1'b0;
`endif
    endtask

    task automatic run_cmd(input string tag, input logic dir, input int steps,
                           input logic stop, input int abort_at);
        int n_exp, n_en, cyc;
        logic w_exp;
        bit seen, bad;
        logic [L-1:0] sd_exp;
        abort_at_g = abort_at;
        ref_run(dir, steps, stop, n_exp, w_exp);
        exp_q.push_back(L'(n_exp));
        check({tag, ":ready_idle"}, 32'(Cmd_ready), 32'd1);
        Cmd_valid        = 1'b1;
        Cmd_dir          = dir;
        Cmd_steps        = L'(steps);
        Cmd_stop_on_wrap = stop;
        tick;
        Cmd_valid        = 1'b0;
        Cmd_dir          = 1'($urandom_range(0, 1));
        Cmd_steps        = L'($urandom);
        Cmd_stop_on_wrap = 1'($urandom_range(0, 1));
        wait_done(dir, 200, n_en, cyc, seen, bad);
        abort_at_g = 0;
        check({tag, ":done_seen"}, 32'(seen), 32'd1);
        check({tag, ":en_cycles"}, 32'(n_en), 32'(n_exp));
        check({tag, ":done_latency"}, 32'(cyc), 32'(n_exp));
        check({tag, ":run_outputs"}, 32'(bad), 32'd0);
        check({tag, ":done_busy"}, {30'd0, Busy, Count_en}, 32'd2);
        tick;
        sd_exp = exp_q.pop_front();
        check({tag, ":pulse_once"}, 32'(Done_pulse), 32'd0);
        check({tag, ":back_idle"}, {29'd0, Cmd_ready, Busy, Count_en}, 32'd4);
        check({tag, ":steps_done"}, 32'(Steps_done), 32'(sd_exp));
        check({tag, ":wrap_flag"}, 32'(Wrap_flag), 32'(w_exp));
        check({tag, ":dir_hold"}, 32'(Up_Down_Ctrl), 32'(dir));
        repeat ($urandom_range(0, 3)) begin
            Overflow_intr  = 1'($urandom_range(0, 1));
            Underflow_intr = 1'($urandom_range(0, 1));
            tick;
        end
        Overflow_intr  = 1'b0;
        Underflow_intr = 1'b0;
        check({tag, ":hold"}, {15'd0, Wrap_flag, Steps_done}, {15'd0, w_exp, sd_exp});
    endtask

    initial begin
        int n_en, cyc;
        bit seen, bad;
        Reset            = 1'b1;
        Cmd_valid        = 1'b0;
        Cmd_dir          = 1'b0;
        Cmd_steps        = '0;
        Cmd_stop_on_wrap = 1'b0;
        Overflow_intr    = 1'b0;
        Underflow_intr   = 1'b0;
`ifdef COUNTER_SEQUENCER_ABORT_EN
        Abort            = 1'b0;
`endif
        clear_sched();

        tick;
        tick;
        check("reset:ready", 32'(Cmd_ready), 32'd1);
        check("reset:ctl", {28'd0, Busy, Count_en, Up_Down_Ctrl, Done_pulse}, 32'd0);
        check("reset:status", {15'd0, Wrap_flag, Steps_done}, 32'd0);
        Reset = 1'b0;

        run_cmd("basic", 1'b0, 5, 1'b0, 0);
        run_cmd("zero", 1'b1, 0, 1'b1, 0);

        // Counter model: 4-bit counter starting at 4'hE, Overflow_intr registered one
        // cycle after the F->0 step, so it is visible in enabled cycle c when (14+c)%16==0.
        clear_sched();
        for (int c = 1; c < 64; c++) ovf_s[c] = ((14 + c) % 16 == 0);
        run_cmd("wrap_stop", 1'b0, 10, 1'b1, 0);
        run_cmd("wrap_nostop", 1'b0, 10, 1'b0, 0);

        for (int i = 0; i < 64; i++) begin
            ovf_s[i] = 1'b1;
            unf_s[i] = 1'b0;
        end
        run_cmd("dir_filter", 1'b1, 4, 1'b1, 0);

        // Reset in the 7th enabled cycle of a 20-step down run.
        clear_sched();
        Cmd_valid = 1'b1; Cmd_dir = 1'b1; Cmd_steps = L'(20); Cmd_stop_on_wrap = 1'b0;
        tick;
        Cmd_valid = 1'b0;
        repeat (6) tick;
        check("rst_mid:in_run", {15'd0, Count_en, Steps_done}, {15'd0, 1'b1, L'(6)});
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        check("rst_mid:ctl", {28'd0, Count_en, Busy, Cmd_ready, Done_pulse}, 32'd2);
        check("rst_mid:status", {14'd0, Up_Down_Ctrl, Wrap_flag, Steps_done}, 32'd0);
        tick;
        check("rst_mid:no_pulse", 32'(Done_pulse), 32'd0);

        // Reset wins over an accept on the same edge.
        Cmd_valid = 1'b1; Cmd_steps = L'(3); Reset = 1'b1;
        tick;
        Reset = 1'b0; Cmd_valid = 1'b0;
        check("rst_prio", {30'd0, Cmd_ready, Count_en}, 32'd2);

        // Backpressure: a second command held valid through the first run.
        Cmd_valid = 1'b1; Cmd_dir = 1'b0; Cmd_steps = L'(3); Cmd_stop_on_wrap = 1'b0;
        tick;
        Cmd_dir = 1'b1; Cmd_steps = L'(2);
        wait_done(1'b0, 100, n_en, cyc, seen, bad);
        check("bp:first_len", 32'(n_en), 32'd3);
        check("bp:first_run", 32'(bad), 32'd0);
        check("bp:ready_at_done", {30'd0, Done_pulse, Cmd_ready}, 32'd2);
        tick;
        check("bp:idle_gap", {29'd0, Cmd_ready, Count_en, Busy}, 32'd4);
        check("bp:first_steps", 32'(Steps_done), 32'd3);
        tick;
        Cmd_valid = 1'b0;
        check("bp:second_start", {30'd0, Count_en, Up_Down_Ctrl}, 32'd3);
        wait_done(1'b1, 100, n_en, cyc, seen, bad);
        check("bp:second_len", 32'(n_en), 32'd2);
        tick;
        check("bp:second_steps", 32'(Steps_done), 32'd2);

        for (int r = 0; r < 10; r++) begin
            logic d, s;
            int st;
            d  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            st = $urandom_range(0, 12);
            for (int i = 0; i < 64; i++) begin
                ovf_s[i] = ($urandom_range(0, 7) == 0);
                unf_s[i] = ($urandom_range(0, 7) == 0);
            end
            run_cmd($sformatf("rand%0d", r), d, st, s, 0);
        end

`ifdef COUNTER_SEQUENCER_ABORT_EN
        clear_sched();
        run_cmd("abort", 1'b0, 8, 1'b0, 3);
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        check("abort_idle", {30'd0, Cmd_ready, Done_pulse}, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
